// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA 640x480@60 timing generator with registered, blanked 1-bit colour.
// Define VGA_FRAME_TICK_EN to generate the one-clock frame_tick pulse at frame wrap.
module vga_sync_gen #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       red_in,
   input  logic       green_in,
   input  logic       blue_in,
   output logic [9:0] x_crd,
   output logic [9:0] y_crd,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       red,
   output logic       green,
   output logic       blue,
   output logic       frame_tick
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic [9:0] H_MAX  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_MAX  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    x_q, x_d, y_q, y_d;
   logic          hs_q, hs_d, vs_q, vs_d, vid_q, vid_d;
   logic          r_q, r_d, g_q, g_d, b_q, b_d;
   logic          x_end, y_end, act;

   // Output stage describes the pre-edge pixel, so sync/colour lag x_crd by one pixel.
   always_comb begin
      x_end = x_q == H_MAX;
      y_end = y_q == V_MAX;
      act   = x_q < H_ACT && y_q < V_ACT;
      div_d = pix_tick ? '0 : div_q + 1'b1;
      x_d   = pix_tick ? (x_end ? '0 : x_q + 10'd1) : x_q;
      y_d   = pix_tick && x_end ? (y_end ? '0 : y_q + 10'd1) : y_q;
      vid_d = pix_tick ? act : vid_q;
      hs_d  = pix_tick ? !(x_q >= HS_LO && x_q < HS_HI) : hs_q;
      vs_d  = pix_tick ? !(y_q >= VS_LO && y_q < VS_HI) : vs_q;
      r_d   = pix_tick ? red_in & act : r_q;
      g_d   = pix_tick ? green_in & act : g_q;
      b_d   = pix_tick ? blue_in & act : b_q;
   end

`ifdef VGA_FRAME_TICK_EN
   logic ft_q;
   assign frame_tick = ft_q;
`else
   assign frame_tick = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         vid_q <= 1'b0;
         r_q   <= 1'b0;
         g_q   <= 1'b0;
         b_q   <= 1'b0;
`ifdef VGA_FRAME_TICK_EN
         ft_q  <= 1'b0;
`endif
      end else begin
         div_q <= div_d;
         x_q   <= x_d;
         y_q   <= y_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         vid_q <= vid_d;
         r_q   <= r_d;
         g_q   <= g_d;
         b_q   <= b_d;
`ifdef VGA_FRAME_TICK_EN
         ft_q  <= pix_tick && x_end && y_end;
`endif
      end
   end

   assign pix_tick = div_q == DIV_MAX;
   assign x_crd    = x_q;
   assign y_crd    = y_q;
   assign hsync    = hs_q;
   assign vsync    = vs_q;
   assign video_on = vid_q;
   assign red      = r_q;
   assign green    = g_q;
   assign blue     = b_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized check of vga_sync_gen against an arithmetic timing model.
// Shrunken line/frame geometry keeps several full frames within a short run.
module tb_vga_sync_gen;
   localparam int CD = 4;
   localparam int HA = 16, HF = 2, HS = 4, HB = 3;
   localparam int VA = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic clk = 1'b0, rst = 1'b1, red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
   logic [9:0] x_crd, y_crd;
   logic pix_tick, hsync, vsync, video_on, red, green, blue, frame_tick;

   vga_sync_gen #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk(clk), .rst(rst), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .x_crd(x_crd), .y_crd(y_crd), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int e = 0;
   logic mr = 0, mg = 0, mb = 0;
   logic hs_prev = 1, vs_prev = 1;
   int hs_w = 0, vs_w = 0, frames = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit in_act(input int p);
      return (p % HT) < HA && ((p / HT) % VT) < VA;
   endfunction

   // One clock edge: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      logic r, ci_r, ci_g, ci_b;
      int t, p, px, py;
      bit tick_edge;
      r = rst; ci_r = red_in; ci_g = green_in; ci_b = blue_in;
      @(posedge clk);
      tick_edge = 0;
      if (r) begin
         e = 0; mr = 0; mg = 0; mb = 0;
      end else begin
         e++;
         if (e % CD == 0) begin
            tick_edge = 1;
            p = e / CD - 1;
            mr = ci_r & in_act(p); mg = ci_g & in_act(p); mb = ci_b & in_act(p);
         end
      end
      #1;
      t = e / CD;
      p = t - 1; px = p % HT; py = (p / HT) % VT;
      check("x_crd", x_crd, t % HT);
      check("y_crd", y_crd, (t / HT) % VT);
      check("pix_tick", pix_tick, (e % CD) == CD - 1);
      check("video_on", video_on, t > 0 && in_act(p));
      check("hsync", hsync, !(t > 0 && px >= HA + HF && px < HA + HF + HS));
      check("vsync", vsync, !(t > 0 && py >= VA + VF && py < VA + VF + VS));
      check("red", red, mr);
      check("green", green, mg);
      check("blue", blue, mb);
`ifdef VGA_FRAME_TICK_EN
      check("frame_tick", frame_tick, tick_edge && t > 0 && t % (HT * VT) == 0);
`else
      check("frame_tick", frame_tick, 0);
`endif
      if (tick_edge && t > 0 && t % (HT * VT) == 0) frames++;
      // Pulse widths, measured in clocks; any reset discards a partial measurement.
      if (r) begin
         hs_w = 0; vs_w = 0;
      end else begin
         if (!hsync) hs_w++;
         if (!vsync) vs_w++;
         if (hsync && !hs_prev && hs_w > 0) check("hsync_width", hs_w, HS * CD);
         if (vsync && !vs_prev && vs_w > 0) check("vsync_width", vs_w, VS * HT * CD);
         if (hsync) hs_w = 0;
         if (vsync) vs_w = 0;
      end
      hs_prev = hsync; vs_prev = vsync;
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 5; i++) step();
      rst = 0;
      for (int i = 0; i < 30000; i++) begin
         if (rst) rst = $urandom_range(0, 2) == 0;
         else rst = $urandom_range(0, 4999) == 0;
         red_in = 1'($urandom); green_in = 1'($urandom); blue_in = 1'($urandom);
         step();
      end
      rst = 0;
      check("frames_seen", frames > 3, 1);
      // Reset in the middle of a vsync line while hsync is low.
      guard = 0;
      while (!(hsync == 0 && vsync == 0) && guard < 4 * HT * VT * CD) begin
         red_in = 1'($urandom); green_in = 1'($urandom); blue_in = 1'($urandom);
         step();
         guard++;
      end
      check("midreset_reach", hsync == 0 && vsync == 0, 1);
      rst = 1;
      step();
      check("midreset_hsync", hsync, 1);
      check("midreset_vsync", vsync, 1);
      rst = 0;
      for (int i = 0; i < 2 * HT * CD; i++) begin
         red_in = 1'($urandom); green_in = 1'($urandom); blue_in = 1'($urandom);
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 Hz timing generator: the producer side of the pixel-coordinate interface that the game renderer consumes. It divides the system clock down to a pixel tick and runs the horizontal and vertical counters that drive `x_crd`/`y_crd`. It registers the renderer's 1-bit colour channels and blanks them outside the active area. It emits hsync/vsync aligned to the registered colour, plus an optional one-cycle frame tick for game logic.

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz); ≥2
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal pixels; H_TOTAL = sum = 800
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical lines; V_TOTAL = sum = 525
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `red_in`, `green_in`, `blue_in` in 1 each: renderer colour for the current (`x_crd`,`y_crd`)
- `x_crd` out 10: horizontal counter, 0..H_TOTAL-1
- `y_crd` out 10: vertical counter, 0..V_TOTAL-1
- `pix_tick` out 1: high for one clk every CLK_DIV clks
- `hsync`, `vsync` out 1 each: active-low, registered
- `video_on` out 1: registered active-area flag, aligned with RGB
- `red`, `green`, `blue` out 1 each: registered, blanked colour to DAC pins
- `frame_tick` out 1: one-clk pulse at frame wrap (see Configuration)

## Operation
- Divider: `div_cnt` counts 0..CLK_DIV-1 and wraps. `pix_tick = (div_cnt == CLK_DIV-1)`, combinational from the register.
- On a clk edge with `pix_tick`:
  - `x_crd` increments. At H_TOTAL-1 it wraps to 0 and `y_crd` increments.
  - `y_crd` wraps from V_TOTAL-1 to 0 only when `x_crd` wraps.
- No state changes on edges without `pix_tick`, apart from `div_cnt`. `frame_tick` also returns low.
- Output stage. On the same pix_tick edge, from the pre-edge (x,y):
  - `video_on <= x < H_ACTIVE && y < V_ACTIVE`
  - `hsync <= !(x >= H_ACTIVE+H_FP && x < H_ACTIVE+H_FP+H_SYNC)`, i.e. low for x in 656..751
  - `vsync <= !(y >= V_ACTIVE+V_FP && y < V_ACTIVE+V_FP+V_SYNC)`, i.e. low for y in 490..491
  - `red/green/blue <= *_in & active`
- Colour inputs are sampled only on pix_tick edges. They may change freely between ticks.
- All comparisons are unsigned 10-bit. Counters never exceed TOTAL-1.
- Reset values: `div_cnt`=0, `x_crd`=0, `y_crd`=0, `hsync`=1, `vsync`=1, `video_on`=0, RGB=0, `frame_tick`=0. `pix_tick` is therefore 0 while reset is held.
- Reset asserted mid-line or mid-frame: on the next edge, all of the above return to their reset values, and no partial sync pulse is held low. Reset has priority over pix_tick on the same edge.

## Timing
- First `pix_tick` occurs in clk cycle CLK_DIV-1 after `rst` deasserts (cycle 0 = first edge with rst low). Period is exactly CLK_DIV clks thereafter.
- Latency is one pixel: hsync/vsync/video_on/RGB during pixel period N+1 describe the counter value held during period N. Sync and colour are mutually aligned; `x_crd` leads them by one pixel.
- hsync low width is exactly H_SYNC pixel periods (384 clks); vsync low width is exactly V_SYNC lines (1600 pixels).
- `frame_tick` is high for exactly one clk: the edge following the pix_tick at which x = H_TOTAL-1 and y = V_TOTAL-1. It coincides with x,y becoming 0,0.

## Configuration
- `VGA_FRAME_TICK_EN` defined: `frame_tick` is generated as above (one pulse per 420,000 pix_ticks). It is intended to replace the free-running game clock divider.
- Undefined: `frame_tick` is tied to 0, and no logic is generated for it. All other behaviour is identical.

## Test plan
- Reset: hold `rst` 5 clks -> all outputs at reset values. Release -> `pix_tick` high at cycles 3, 7, 11…; `x_crd`=1 after cycle 3.
- Line wrap: run to x=799,y=0 and tick -> x=0, y=1. Run to x=799,y=524 and tick -> x=0, y=0. With macro on, `frame_tick`=1 for one clk; with macro off, it stays 0.
- Sync widths: measure hsync -> low first in the pixel period where x=657, low for 96 periods; vsync -> low for 2×800 pixel periods starting one pixel after (x=0,y=490).
- Blanking: drive `red_in`=`green_in`=`blue_in`=1 constantly -> RGB=1 only while video_on=1. Count 640 high pixels per active line, 0 on lines 480..524.
- Colour alignment: set `green_in`=1 only when x_crd==100 -> `green` high for exactly one pixel period, starting one pixel after x_crd showed 100.
- Mid-frame reset: assert `rst` for one clk at x=700,y=491 (hsync and vsync low) -> next edge gives hsync=vsync=1, x=y=0. Restart timing matches the first test.
